// File: rtl/cfu_pim_pkg.sv
// Shared definitions for the PIM CFU command sequencer: op encodings,
// FSM state/phase enums, response actions and function_id field layout.
package cfu_pim_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MAC   = 2'b10;

    // Row address occupies the top ROW_W bits of function_id; op sits in [1:0].
    localparam int unsigned ROW_W  = 8;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitRsp,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        PhLoad,
        PhVerify,
        PhMac
    } phase_e;

    // Decision taken when a response is accepted.
    typedef enum logic [2:0] {
        ActNone,
        ActAbort,
        ActFetch,
        ActVerify,
        ActMac,
        ActDone
    } action_e;

endpackage

// File: rtl/cfu_pim_sequencer.sv
// Initiator-side CFU command sequencer: loads a weight stream into PIM rows
// via write commands, then issues MAC commands and returns the last MAC word.
// Optional feature macro: CFU_SEQ_READBACK_EN inserts a read-back verify of
// each written row; without it writes are unchecked and no hold register exists.
module cfu_pim_sequencer
    import cfu_pim_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned FWIDTH = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        num_rows,
    input  logic [5:0]        mac_count,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DWIDTH-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DWIDTH-1:0] result,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [FWIDTH-1:0] cmd_payload_function_id,
    output logic [DWIDTH-1:0] cmd_payload_inputs_0,
    output logic [DWIDTH-1:0] cmd_payload_inputs_1,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic              rsp_payload_response_ok,
    input  logic [DWIDTH-1:0] rsp_payload_outputs_0
);

    state_e      state_q;
    phase_e      phase_q;
    logic [8:0]  row_q;
    logic [7:0]  num_rows_q;
    logic [5:0]  mac_q;

    logic        rsp_fire;
    logic [8:0]  row_next;
    action_e     after_row;
    action_e     act;
    logic        row_done;
    logic        mac_rsp;

`ifdef CFU_SEQ_READBACK_EN
    // Written word kept for comparison against the read-back response.
    logic [DWIDTH-1:0] hold_q;
    localparam phase_e ROW_END_PHASE = PhVerify;
`else
    localparam phase_e ROW_END_PHASE = PhLoad;
`endif

    assign cmd_payload_inputs_1 = '0;

    function automatic logic [FWIDTH-1:0] make_fid(input logic [7:0] row, input logic [1:0] op);
        logic [FWIDTH-1:0] fid;
        fid = '0;
        fid[FWIDTH-1 -: ROW_W] = row;
        fid[OP_W-1:0] = op;
        return fid;
    endfunction

    // Decide what to do with the response accepted this cycle (if any).
    always_comb begin
        rsp_fire = rsp_ready && rsp_valid &&
                   ((state_q == StWaitRsp) || ((state_q == StIssue) && cmd_ready));
        row_next = row_q + 9'd1;
        if (row_next < {1'b0, num_rows_q}) begin
            after_row = ActFetch;
        end else if (mac_q != 6'd0) begin
            after_row = ActMac;
        end else begin
            after_row = ActDone;
        end

        act = ActNone;
        if (rsp_fire) begin
            if (!rsp_payload_response_ok) begin
                act = ActAbort;
            end else begin
                case (phase_q)
`ifdef CFU_SEQ_READBACK_EN
                    PhLoad:   act = ActVerify;
                    PhVerify: act = (rsp_payload_outputs_0 != hold_q) ? ActAbort : after_row;
`else
                    PhLoad:   act = after_row;
`endif
                    PhMac:    act = (mac_q <= 6'd1) ? ActDone : ActMac;
                    default:  act = ActAbort;
                endcase
            end
        end

        row_done = rsp_fire && rsp_payload_response_ok && (phase_q == ROW_END_PHASE) &&
                   (act != ActAbort);
        mac_rsp  = rsp_fire && rsp_payload_response_ok && (phase_q == PhMac);
    end

    // Sequencer FSM with registered handshake, status and payload outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                 <= StIdle;
            phase_q                 <= PhLoad;
            row_q                   <= '0;
            num_rows_q              <= '0;
            mac_q                   <= '0;
            wdata_ready             <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            err                     <= 1'b0;
            result                  <= '0;
            cmd_valid               <= 1'b0;
            rsp_ready               <= 1'b0;
            cmd_payload_function_id <= '0;
            cmd_payload_inputs_0    <= '0;
`ifdef CFU_SEQ_READBACK_EN
            hold_q                  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        num_rows_q <= num_rows;
                        mac_q      <= mac_count;
                        row_q      <= '0;
                        err        <= 1'b0;
                        result     <= '0;
                        busy       <= 1'b1;
                        if (num_rows != 8'd0) begin
                            wdata_ready <= 1'b1;
                            state_q     <= StFetch;
                        end else if (mac_count != 6'd0) begin
                            cmd_payload_function_id <= make_fid(8'd0, OP_MAC);
                            cmd_payload_inputs_0    <= '0;
                            phase_q                 <= PhMac;
                            cmd_valid               <= 1'b1;
                            rsp_ready               <= 1'b1;
                            state_q                 <= StIssue;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StFetch: begin
                    if (wdata_valid) begin
                        cmd_payload_inputs_0    <= wdata;
`ifdef CFU_SEQ_READBACK_EN
                        hold_q                  <= wdata;
`endif
                        cmd_payload_function_id <= make_fid(row_q[7:0], OP_WRITE);
                        phase_q                 <= PhLoad;
                        wdata_ready             <= 1'b0;
                        cmd_valid               <= 1'b1;
                        rsp_ready               <= 1'b1;
                        state_q                 <= StIssue;
                    end
                end
                StIssue: begin
                    // Same-cycle response is handled by the response block below.
                    if (cmd_ready && !rsp_fire) begin
                        cmd_valid <= 1'b0;
                        state_q   <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (row_done) begin
                row_q <= row_next;
            end
            if (mac_rsp) begin
                result <= rsp_payload_outputs_0;
                mac_q  <= mac_q - 6'd1;
            end

            case (act)
                ActAbort, ActDone: begin
                    if (act == ActAbort) begin
                        err <= 1'b1;
                    end
                    cmd_valid   <= 1'b0;
                    rsp_ready   <= 1'b0;
                    wdata_ready <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state_q     <= StDone;
                end
                ActFetch: begin
                    cmd_valid   <= 1'b0;
                    rsp_ready   <= 1'b0;
                    wdata_ready <= 1'b1;
                    state_q     <= StFetch;
                end
                ActVerify: begin
                    cmd_payload_function_id <= make_fid(row_q[7:0], OP_READ);
                    cmd_payload_inputs_0    <= '0;
                    phase_q                 <= PhVerify;
                    cmd_valid               <= 1'b1;
                    rsp_ready               <= 1'b1;
                    state_q                 <= StIssue;
                end
                ActMac: begin
                    cmd_payload_function_id <= make_fid(8'd0, OP_MAC);
                    cmd_payload_inputs_0    <= '0;
                    phase_q                 <= PhMac;
                    cmd_valid               <= 1'b1;
                    rsp_ready               <= 1'b1;
                    state_q                 <= StIssue;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_pim_sequencer.sv
// Scoreboard bench for cfu_pim_sequencer: expected commands and completions
// are queued by the job sequences; a monitor pops and compares them as the
// DUT presents command handshakes and done pulses.
module tb_cfu_pim_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_rows = '0;
    logic [5:0]  mac_count = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] result;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic        rsp_ok = 1'b1;
    logic [31:0] rsp_out = '0;

    cfu_pim_sequencer #(.DWIDTH(32), .FWIDTH(10)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .num_rows                (num_rows),
        .mac_count               (mac_count),
        .wdata_valid             (wdata_valid),
        .wdata_ready             (wdata_ready),
        .wdata                   (wdata),
        .busy                    (busy),
        .done                    (done),
        .err                     (err),
        .result                  (result),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_ok),
        .rsp_payload_outputs_0   (rsp_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [41:0] exp_cmd[$];   // {function_id, inputs_0}
    logic [32:0] exp_done[$];  // {err, result}
    logic [31:0] wq[$];
    logic [31:0] mac_vals[$];
    logic [31:0] mem [0:255];

    // Responder configuration
    int lat = 0;
    int stall_idx = -1;
    int stall_left = 0;
    int fail_write = -1;
    int corrupt_row = -1;
    int nacc = 0;
    int wr_n = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_w(input int row, input logic [31:0] d);
        logic [7:0] r;
        r = row[7:0];
        exp_cmd.push_back({r, 2'b01, d});
    endtask

    task automatic push_r(input int row);
        logic [7:0] r;
        r = row[7:0];
`ifdef CFU_SEQ_READBACK_EN
        exp_cmd.push_back({r, 2'b00, 32'h0});
`else
        if (r == 8'hff) exp_cmd.push_back({r, 2'b00, 32'h0}); // never taken: row < 255
`endif
    endtask

    // Weight stream source
    initial begin
        logic fire;
        fire = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wq.delete();
                fire = 1'b0;
                wdata_valid = 1'b0;
            end else begin
                if (fire && wq.size() > 0) void'(wq.pop_front());
                wdata_valid = (wq.size() > 0);
                wdata = (wq.size() > 0) ? wq[0] : 32'h0;
                fire = wdata_valid && wdata_ready;
            end
        end
    end

    task automatic respond(input logic [9:0] f, input logic [31:0] d);
        rsp_valid = 1'b1;
        rsp_ok = 1'b1;
        rsp_out = 32'h0;
        case (f[1:0])
            2'b01: begin
                wr_n++;
                mem[f[9:2]] = d;
                if (wr_n == fail_write) rsp_ok = 1'b0;
            end
            2'b00: rsp_out = mem[f[9:2]] ^ ((int'(f[9:2]) == corrupt_row) ? 32'h1 : 32'h0);
            2'b10: rsp_out = (mac_vals.size() > 0) ? mac_vals.pop_front() : 32'h0;
            default: rsp_ok = 1'b0;
        endcase
    endtask

    // CFU responder with configurable latency and cmd_ready stall
    initial begin
        logic       outstanding;
        int         cnt;
        logic [9:0] sf;
        logic [31:0] sd;
        outstanding = 1'b0;
        cnt = 0;
        sf = '0;
        sd = '0;
        forever begin
            @(negedge clk);
            cmd_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_ok = 1'b1;
            rsp_out = 32'h0;
            if (reset) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                if (cnt == 0) begin
                    respond(sf, sd);
                    if (rsp_ready) outstanding = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (cmd_valid) begin
                if (nacc == stall_idx && stall_left > 0) begin
                    stall_left--;
                end else begin
                    cmd_ready = 1'b1;
                    nacc++;
                    if (lat == 0) begin
                        respond(fid, in0);
                    end else begin
                        outstanding = 1'b1;
                        cnt = lat - 1;
                        sf = fid;
                        sd = in0;
                    end
                end
            end
        end
    end

    // Monitor: compare command handshakes and done pulses against the scoreboard
    initial begin
        logic        mon_out;
        logic        prev_stall;
        logic [41:0] prev_pl;
        logic [41:0] e;
        logic [32:0] ed;
        mon_out = 1'b0;
        prev_stall = 1'b0;
        prev_pl = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                mon_out = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (cmd_valid) begin
                    chk("no_cmd_while_outstanding", {63'b0, mon_out}, 64'd0);
                    if (prev_stall) chk("payload_stable", {22'b0, fid, in0}, {22'b0, prev_pl});
                end
                if (cmd_valid && cmd_ready) begin
                    mon_out = 1'b1;
                    chk("inputs_1_zero", {32'b0, in1}, 64'd0);
                    if (exp_cmd.size() == 0) begin
                        chk("cmd_expected", 64'(exp_cmd.size()), 64'd1);
                    end else begin
                        e = exp_cmd.pop_front();
                        chk("cmd_payload", {22'b0, fid, in0}, {22'b0, e});
                    end
                end
                if (rsp_valid && rsp_ready) mon_out = 1'b0;
                prev_stall = cmd_valid && !cmd_ready;
                prev_pl = {fid, in0};
                if (done) begin
                    done_cnt++;
                    chk("busy_low_at_done", {63'b0, busy}, 64'd0);
                    if (exp_done.size() == 0) begin
                        chk("done_expected", 64'(exp_done.size()), 64'd1);
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_err_result", {31'b0, err, result}, {31'b0, ed});
                    end
                end
            end
        end
    end

    task automatic run_job(input int rows, input int mac, input int lat_i, input int stall_i,
                           input int failw, input int corrupt, input bit again);
        int d0;
        lat = lat_i;
        stall_idx = stall_i;
        stall_left = 5;
        fail_write = failw;
        corrupt_row = corrupt;
        nacc = 0;
        wr_n = 0;
        d0 = done_cnt;
        @(negedge clk);
        #2;
        num_rows = rows[7:0];
        mac_count = mac[5:0];
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        if (rows > 0) chk("wready_after_start", {63'b0, wdata_ready}, 64'd1);
        if (again) begin
            @(negedge clk);
            #2;
            num_rows = 8'd7;
            start = 1'b1;
            @(negedge clk);
            #2;
            start = 1'b0;
        end
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt != d0) break;
            @(negedge clk);
        end
        chk("job_done", 64'(done_cnt), 64'(d0 + 1));
        repeat (5) @(negedge clk);
        #2;
        chk("idle_after_job", {63'b0, busy}, 64'd0);
        chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
        wq.delete();
        exp_cmd.delete();
        exp_done.delete();
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #2;
        chk("rst_ctrl", {58'b0, cmd_valid, rsp_ready, wdata_ready, busy, done, err}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_fid", {54'b0, fid}, 64'd0);
        chk("rst_inputs", {in1, in0}, 64'd0);
        reset = 1'b0;

        // Job 1: three writes, zero-latency responder, no MAC
        wq.push_back(32'hA5A5_0001);
        wq.push_back(32'hA5A5_0002);
        wq.push_back(32'hA5A5_0003);
        exp_cmd.push_back({10'h001, 32'hA5A5_0001});
        push_r(0);
        exp_cmd.push_back({10'h005, 32'hA5A5_0002});
        push_r(1);
        exp_cmd.push_back({10'h009, 32'hA5A5_0003});
        push_r(2);
        exp_done.push_back({1'b0, 32'h0});
        run_job(3, 0, 0, -1, -1, -1, 1'b0);

        // Job 2: MAC only, result is last response (40)
        mac_vals = '{32'd10, 32'd20, 32'd30, 32'd40};
        repeat (4) exp_cmd.push_back({10'h002, 32'h0});
        exp_done.push_back({1'b0, 32'd40});
        run_job(0, 4, 0, -1, -1, -1, 1'b0);

        // Job 3: cmd_ready stalled 5 cycles on second command, 3-cycle responses
        for (int r = 0; r < 4; r++) begin
            wq.push_back(32'h1000_0000 + 32'(r));
            push_w(r, 32'h1000_0000 + 32'(r));
            push_r(r);
        end
        mac_vals = '{32'd77};
        exp_cmd.push_back({10'h002, 32'h0});
        exp_done.push_back({1'b0, 32'd77});
        run_job(4, 1, 3, 1, -1, -1, 1'b0);

        // Job 4: second write fails -> abort, no further commands
        for (int r = 0; r < 4; r++) wq.push_back(32'h2000_0000 + 32'(r));
        push_w(0, 32'h2000_0000);
        push_r(0);
        push_w(1, 32'h2000_0001);
        exp_done.push_back({1'b1, 32'h0});
        run_job(4, 2, 0, -1, 2, -1, 1'b0);

        // Job 5: read-back of row 1 corrupted
        for (int r = 0; r < 3; r++) wq.push_back(32'hB000_0000 + 32'(r));
        push_w(0, 32'hB000_0000);
        push_r(0);
        push_w(1, 32'hB000_0001);
        push_r(1);
`ifdef CFU_SEQ_READBACK_EN
        exp_done.push_back({1'b1, 32'h0});
`else
        push_w(2, 32'hB000_0002);
        exp_done.push_back({1'b0, 32'h0});
`endif
        run_job(3, 0, 0, -1, -1, 1, 1'b0);

        // Job 6: reset while waiting for a response, then clean restart
        lat = 3;
        stall_idx = -1;
        fail_write = -1;
        corrupt_row = -1;
        nacc = 0;
        wr_n = 0;
        for (int r = 0; r < 3; r++) wq.push_back(32'hC000_0000 + 32'(r));
        push_w(0, 32'hC000_0000);
        @(negedge clk);
        #2;
        num_rows = 8'd3;
        mac_count = 6'd0;
        start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_cmd.size() == 0) break;
            @(negedge clk);
        end
        chk("first_cmd_before_reset", 64'(exp_cmd.size()), 64'd0);
        @(negedge clk);
        #2;
        chk("busy_in_wait_rsp", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_ctrl", {60'b0, busy, cmd_valid, rsp_ready, wdata_ready}, 64'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        exp_cmd.delete();

        for (int r = 0; r < 2; r++) begin
            wq.push_back(32'hD000_0000 + 32'(r));
            push_w(r, 32'hD000_0000 + 32'(r));
            push_r(r);
        end
        mac_vals = '{32'd5};
        exp_cmd.push_back({10'h002, 32'h0});
        exp_done.push_back({1'b0, 32'd5});
        run_job(2, 1, 0, -1, -1, -1, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cfu_pim_sequencer.md
# cfu_pim_sequencer

Initiator-side command sequencer for the PIM custom function unit (CFU). On a `start` pulse it streams a weight image into PIM rows through CFU write commands, then issues a programmed number of MAC commands and returns the final MAC response word. It sits between the host/DMA weight stream and the CFU command/response port, replacing software-issued CFU instructions for bulk load-and-compute jobs.

## Interface
- `DWIDTH`, 32, CFU data width for `inputs_0/1` and `outputs_0`.
- `FWIDTH`, 10, function_id width; row address in `[FWIDTH-1:FWIDTH-8]`, op in `[1:0]`.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `num_rows`  in  8  rows to load (0 = skip load); sampled at start.
- `mac_count`  in  6  MAC commands to issue (0 = none); sampled at start.
- `wdata_valid` / `wdata_ready`  in / out  1 / 1  weight stream handshake.
- `wdata`  in  DWIDTH  weight word for the current row.
- `busy`  out  1  high from the cycle after start until done.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with done; sticky until next start.
- `result`  out  DWIDTH  last MAC response word; held until next start.
- `cmd_valid` / `cmd_ready`  out / in  1 / 1  CFU command handshake.
- `cmd_payload_function_id`  out  FWIDTH  `{row[7:0], op[1:0]}`; op 01 write, 00 read, 10 MAC.
- `cmd_payload_inputs_0`  out  DWIDTH  write data; 0 for read/MAC.
- `cmd_payload_inputs_1`  out  DWIDTH  constant 0.
- `rsp_valid` / `rsp_ready`  in / out  1 / 1  CFU response handshake.
- `rsp_payload_response_ok`  in  1  0 flags a failed command.
- `rsp_payload_outputs_0`  in  DWIDTH  response data.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_RSP, DONE; ISSUE/WAIT_RSP are qualified by phase register LOAD, VERIFY, or MAC.
- IDLE: on `start`, latch `num_rows`, `mac_count`, clear row counter, `err`, and `result`. Go to FETCH if `num_rows`>0, else to MAC phase ISSUE if `mac_count`>0, else DONE.
- FETCH: `wdata_ready`=1; on `wdata_valid`, latch `wdata` into `inputs_0`, set op=01, row=row counter, go to ISSUE.
- ISSUE: `cmd_valid`=1 and `rsp_ready`=1. Payload is stable while `cmd_valid && !cmd_ready`. On cmd handshake, go to WAIT_RSP unless a response is accepted in the same cycle, in which case that response is processed immediately.
- WAIT_RSP: `rsp_ready`=1. At most one command is outstanding.
- Response processing:
  - If `response_ok`=0, set `err` and go to DONE, aborting the job.
  - LOAD phase: increment row; go to FETCH if row < `num_rows`, else to MAC phase (or DONE if `mac_count`=0).
  - MAC phase: `result` <= `outputs_0`, decrement the MAC counter, and reissue op=10 with row=0 until the count is exhausted, then go to DONE.
- DONE: `done`=1 for one cycle; `busy` drops the same cycle; return to IDLE.
- Row counter is 9 bits, so `num_rows`=255 writes rows 0..254 with no wrap. `start` during `busy` is ignored.
- Reset mid-job: immediate return to IDLE; any in-flight command is abandoned (`cmd_valid` deasserts asynchronously).

## Timing
- Reset values: `cmd_valid`, `rsp_ready`, `wdata_ready`, `busy`, `done`, `err` all 0; `result`, `function_id`, `inputs_0/1` all 0.
- `start` to first `wdata_ready`: 1 cycle.
- Each command takes at least 1 cycle ISSUE, plus `cmd_ready` stall, plus response latency. A zero-latency responder gives 1 cycle/command, plus 1 FETCH cycle per loaded row.
- `done` is asserted 1 cycle after the final response handshake.

## Configuration
- `CFU_SEQ_READBACK_EN` defined: VERIFY phase is inserted after each LOAD response. It issues a read (op=00) of the same row and compares `outputs_0` with the written word; a mismatch sets `err` and goes to DONE.
- Undefined: no VERIFY phase; writes are unchecked; the comparator and hold register are removed.

## Structure
- Package `cfu_pim_pkg`: op encoding constants (`OP_READ`=2'b00, `OP_WRITE`=2'b01, `OP_MAC`=2'b10), state enum, phase enum, row-address field offsets.
- Single module. No sub-module; the FSM and counters are small enough to keep flat.

## Test plan
- `num_rows`=3, `mac_count`=0, weights A5A5_0001/0002/0003, zero-latency responder → function_ids 0x001, 0x005, 0x009 with matching `inputs_0`; `done` with `err`=0 and `result`=0.
- `num_rows`=0, `mac_count`=4, responder returns 10, 20, 30, 40 → four op=10 commands; `result`=40.
- `cmd_ready` held low 5 cycles mid-load → payload stable and no duplicate commands; `rsp_valid` delayed 3 cycles → no new command issued before the response.
- `response_ok`=0 on 2nd write of 4 → `err`=1, `done` pulses, and no further commands are issued.
- With `CFU_SEQ_READBACK_EN`, responder corrupts readback of row 1 → `err`=1 after the row-1 read; without the macro, the same stimulus completes with `err`=0.
- Reset asserted in WAIT_RSP, then `start` reissued → clean restart from row 0; `start` pulsed while `busy` → ignored.
